// File: rtl/opcode_decoder.sv
// -----------------------------------------------------------------------------
// opcode_decoder
//
// Purpose:
//   Receives the keypad encoder's {op_code, is_op, is_result, is_enter} stream.
//   It turns held keys into single strobes and runs one ALU transaction for each
//   operator+enter pair. It also reports illegal opcodes and an operator that
//   waits too long for enter.
//
// Optional feature (macro OPCODE_DECODER_QUEUE_EN):
//   When this macro is defined, a one-entry holding register keeps the last legal
//   operator strobe seen in ISSUE or WAIT_DONE. On ALU completion the FSM goes to
//   WAIT_ENTER with that operator instead of going to IDLE. When the macro is not
//   defined, strobes in those states are dropped.
//
// Parameters:
//   TIMEOUT_CYC  cycles spent in WAIT_ENTER without enter before the operator is dropped (>=1)
//
// Ports:
//   clk          in   system clock, rising edge
//   rst          in   asynchronous reset, active-high
//   op_code[2:0] in   opcode (3'b001 ADD, 3'b010 SUB, all other values illegal)
//   is_op        in   operator key held
//   is_result    in   result of the operation goes to the display
//   is_enter     in   enter key held
//   alu_done     in   ALU completion pulse, used only in WAIT_DONE
//   alu_start    out  one-cycle ALU launch pulse
//   alu_sub      out  0=add, 1=sub; valid from alu_start until IDLE
//   disp_load    out  one-cycle display load pulse
//   err_illegal  out  one-cycle pulse for an operator strobe with an illegal opcode
//   err_timeout  out  one-cycle pulse when WAIT_ENTER expires
//   busy         out  state is not IDLE
//
// State      | meaning
// -----------+------------------------------------------------
// IDLE       | no operator pending
// WAIT_ENTER | operator latched, waiting for enter or timeout
// ISSUE      | alu_start cycle
// WAIT_DONE  | waiting for the ALU completion pulse
// -----------------------------------------------------------------------------
module opcode_decoder #(
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] op_code,
    input  logic       is_op,
    input  logic       is_result,
    input  logic       is_enter,
    input  logic       alu_done,
    output logic       alu_start,
    output logic       alu_sub,
    output logic       disp_load,
    output logic       err_illegal,
    output logic       err_timeout,
    output logic       busy
);

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_WAIT_ENTER = 2'd1,
        S_ISSUE      = 2'd2,
        S_WAIT_DONE  = 2'd3
    } state_t;

    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0] C_LAST = CW'(TIMEOUT_CYC - 1);
    localparam logic [CW-1:0] C_MAX  = {CW{1'b1}};
    localparam logic [CW-1:0] C_ONE  = CW'(1);

    state_t        r_state;
    state_t        w_state_nxt;

    logic          w_key;
    logic          w_strobe;
    logic          r_key_q;
    logic          r_op_stb;
    logic          r_ent_stb;
    logic [2:0]    r_stb_opc;
    logic          r_stb_res;

    logic          w_legal;
    logic          w_op_legal;
    logic          w_op_illegal;
    logic          w_stb_sub;
    logic          w_expire;

    logic [CW-1:0] r_cnt;
    logic          r_lat_sub;
    logic          r_lat_res;

    // The strobe is registered together with the opcode bits that were present
    // on the key edge. Later changes to op_code while the key is held have no
    // effect.
    assign w_key    = is_op | is_enter;
    assign w_strobe = w_key & ~r_key_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_key_q   <= 1'b0;
            r_op_stb  <= 1'b0;
            r_ent_stb <= 1'b0;
            r_stb_opc <= 3'b000;
            r_stb_res <= 1'b0;
        end else begin
            r_key_q   <= w_key;
            r_op_stb  <= w_strobe & is_op;
            r_ent_stb <= w_strobe & ~is_op;
            r_stb_opc <= op_code;
            r_stb_res <= is_result;
        end
    end

    assign w_legal      = (r_stb_opc == 3'b001) || (r_stb_opc == 3'b010);
    assign w_op_legal   = r_op_stb & w_legal;
    assign w_op_illegal = r_op_stb & ~w_legal;
    assign w_stb_sub    = (r_stb_opc == 3'b010);
    assign w_expire     = (r_cnt == C_LAST);

`ifdef OPCODE_DECODER_QUEUE_EN
    logic r_hold_vld;
    logic r_hold_sub;
    logic r_hold_res;
    logic w_q_vld;
    logic w_q_sub;
    logic w_q_res;

    // A strobe that arrives in the same cycle as alu_done replaces the held entry.
    assign w_q_vld = r_hold_vld | w_op_legal;
    assign w_q_sub = w_op_legal ? w_stb_sub : r_hold_sub;
    assign w_q_res = w_op_legal ? r_stb_res : r_hold_res;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hold_vld <= 1'b0;
            r_hold_sub <= 1'b0;
            r_hold_res <= 1'b0;
        end else if (r_state == S_WAIT_DONE && alu_done) begin
            r_hold_vld <= 1'b0;
        end else if ((r_state == S_ISSUE || r_state == S_WAIT_DONE) && w_op_legal) begin
            r_hold_vld <= 1'b1;
            r_hold_sub <= w_stb_sub;
            r_hold_res <= r_stb_res;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_op_legal)
                    w_state_nxt = S_WAIT_ENTER;
            end
            S_WAIT_ENTER: begin
                // When a strobe arrives on the expiry cycle, the strobe wins.
                if (r_ent_stb)
                    w_state_nxt = S_ISSUE;
                else if (!r_op_stb && w_expire)
                    w_state_nxt = S_IDLE;
            end
            S_ISSUE: begin
                w_state_nxt = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (alu_done) begin
`ifdef OPCODE_DECODER_QUEUE_EN
                    w_state_nxt = w_q_vld ? S_WAIT_ENTER : S_IDLE;
`else
                    w_state_nxt = S_IDLE;
`endif
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Latched operator and timeout counter. The counter saturates and does not wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt     <= '0;
            r_lat_sub <= 1'b0;
            r_lat_res <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_op_legal) begin
                        r_lat_sub <= w_stb_sub;
                        r_lat_res <= r_stb_res;
                        r_cnt     <= '0;
                    end
                end
                S_WAIT_ENTER: begin
                    if (w_op_legal) begin
                        r_lat_sub <= w_stb_sub;
                        r_lat_res <= r_stb_res;
                        r_cnt     <= '0;
                    end else if (r_cnt != C_MAX) begin
                        r_cnt <= r_cnt + C_ONE;
                    end
                end
`ifdef OPCODE_DECODER_QUEUE_EN
                S_WAIT_DONE: begin
                    if (alu_done && w_q_vld) begin
                        r_lat_sub <= w_q_sub;
                        r_lat_res <= w_q_res;
                        r_cnt     <= '0;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    always_comb begin
        alu_start   = 1'b0;
        alu_sub     = 1'b0;
        disp_load   = 1'b0;
        err_illegal = 1'b0;
        err_timeout = 1'b0;
        busy        = (r_state != S_IDLE);
        case (r_state)
            S_IDLE: begin
                err_illegal = w_op_illegal;
            end
            S_WAIT_ENTER: begin
                err_illegal = w_op_illegal;
                err_timeout = ~r_op_stb & ~r_ent_stb & w_expire;
            end
            S_ISSUE: begin
                alu_start = 1'b1;
                alu_sub   = r_lat_sub;
`ifdef OPCODE_DECODER_QUEUE_EN
                err_illegal = w_op_illegal;
`endif
            end
            S_WAIT_DONE: begin
                alu_sub   = r_lat_sub;
                disp_load = alu_done & r_lat_res;
`ifdef OPCODE_DECODER_QUEUE_EN
                err_illegal = w_op_illegal;
`endif
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_opcode_decoder.sv
module tb_opcode_decoder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] op_code = 3'b000;
    logic       is_op = 1'b0;
    logic       is_result = 1'b0;
    logic       is_enter = 1'b0;
    logic       alu_done = 1'b0;
    logic       alu_start, alu_sub, disp_load, err_illegal, err_timeout, busy;

    int n_cmp = 0;
    int n_err = 0;
    int n_start = 0, n_disp = 0, n_ill = 0, n_to = 0;

    opcode_decoder #(.TIMEOUT_CYC(8)) dut (
        .clk(clk), .rst(rst), .op_code(op_code), .is_op(is_op),
        .is_result(is_result), .is_enter(is_enter), .alu_done(alu_done),
        .alu_start(alu_start), .alu_sub(alu_sub), .disp_load(disp_load),
        .err_illegal(err_illegal), .err_timeout(err_timeout), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst) begin
            n_start += int'(alu_start);
            n_disp  += int'(disp_load);
            n_ill   += int'(err_illegal);
            n_to    += int'(err_timeout);
        end
    end

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // The strobe registers on the first edge. The FSM acts on the second edge.
    task automatic press_op(input logic [2:0] opc, input logic res);
        op_code = opc; is_result = res; is_op = 1'b1;
        tick();
        is_op = 1'b0;
        tick();
    endtask

    // The enter strobe is registered when this task returns. ISSUE follows one edge later.
    task automatic press_enter();
        is_enter = 1'b1;
        tick();
        is_enter = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2;
        n_cmp++;
        if ({alu_start, alu_sub, disp_load, err_illegal, err_timeout, busy} !== 6'b0) begin
            n_err++;
            $display("FAIL reset_outputs: got %b want 000000",
                     {alu_start, alu_sub, disp_load, err_illegal, err_timeout, busy});
        end
        tick(2);
        rst = 1'b0;
        tick(2);
        n_cmp++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL reset_idle: busy got %b want 0", busy); end
    endtask

    task automatic test_basic_add();
        int s0, d0;
        s0 = n_start; d0 = n_disp;
        op_code = 3'b001; is_result = 1'b1; is_op = 1'b1;
        tick(5);
        is_op = 1'b0;
        tick();
        n_cmp++;
        if (busy !== 1'b1) begin n_err++; $display("FAIL add_wait_enter: busy got %b want 1", busy); end
        is_enter = 1'b1;
        tick();
        n_cmp++;
        if (alu_start !== 1'b0) begin n_err++; $display("FAIL add_early_start: got %b want 0", alu_start); end
        tick();
        n_cmp++;
        if (alu_start !== 1'b1 || alu_sub !== 1'b0) begin
            n_err++; $display("FAIL add_start: start/sub got %b%b want 10", alu_start, alu_sub);
        end
        tick();
        is_enter = 1'b0;
        tick(2);
        n_cmp++;
        if (disp_load !== 1'b0) begin n_err++; $display("FAIL add_disp_early: got %b want 0", disp_load); end
        tick();
        alu_done = 1'b1;
        #1;
        n_cmp++;
        if (disp_load !== 1'b1 || alu_sub !== 1'b0) begin
            n_err++; $display("FAIL add_disp: disp/sub got %b%b want 10", disp_load, alu_sub);
        end
        tick();
        alu_done = 1'b0;
        n_cmp++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL add_done_idle: busy got %b want 0", busy); end
        tick(2);
        n_cmp++;
        if (n_start - s0 !== 1 || n_disp - d0 !== 1) begin
            n_err++; $display("FAIL add_counts: start %0d disp %0d want 1 1", n_start - s0, n_disp - d0);
        end
    endtask

    task automatic test_last_wins();
        int s0;
        logic sub_seen;
        s0 = n_start; sub_seen = 1'b1;
        press_op(3'b010, 1'b0);
        press_op(3'b001, 1'b0);
        press_enter();
        tick();
        sub_seen = alu_sub;
        n_cmp++;
        if (alu_start !== 1'b1 || sub_seen !== 1'b0) begin
            n_err++; $display("FAIL last_wins: start/sub got %b%b want 10", alu_start, sub_seen);
        end
        tick(2);
        alu_done = 1'b1;
        tick();
        alu_done = 1'b0;
        tick(2);
        n_cmp++;
        if (n_start - s0 !== 1 || busy !== 1'b0) begin
            n_err++; $display("FAIL last_wins_count: starts %0d busy %b want 1 0", n_start - s0, busy);
        end
    endtask

    task automatic test_illegal();
        int s0, i0;
        s0 = n_start; i0 = n_ill;
        op_code = 3'b011; is_op = 1'b1;
        tick();
        n_cmp++;
        if (err_illegal !== 1'b1) begin n_err++; $display("FAIL illegal_pulse: got %b want 1", err_illegal); end
        tick();
        n_cmp++;
        if (err_illegal !== 1'b0 || busy !== 1'b0) begin
            n_err++; $display("FAIL illegal_after: err/busy got %b%b want 00", err_illegal, busy);
        end
        is_op = 1'b0;
        tick(2);
        n_cmp++;
        if (n_ill - i0 !== 1 || n_start - s0 !== 0) begin
            n_err++; $display("FAIL illegal_counts: ill %0d start %0d want 1 0", n_ill - i0, n_start - s0);
        end
    endtask

    task automatic test_timeout();
        int s0, t0;
        s0 = n_start; t0 = n_to;
        press_op(3'b001, 1'b1);
        n_cmp++;
        if (busy !== 1'b1) begin n_err++; $display("FAIL to_entry: busy got %b want 1", busy); end
        tick(6);
        n_cmp++;
        if (err_timeout !== 1'b0 || busy !== 1'b1) begin
            n_err++; $display("FAIL to_early: to/busy got %b%b want 01", err_timeout, busy);
        end
        tick();
        n_cmp++;
        if (err_timeout !== 1'b1 || busy !== 1'b1) begin
            n_err++; $display("FAIL to_pulse: to/busy got %b%b want 11", err_timeout, busy);
        end
        tick();
        n_cmp++;
        if (err_timeout !== 1'b0 || busy !== 1'b0) begin
            n_err++; $display("FAIL to_idle: to/busy got %b%b want 00", err_timeout, busy);
        end
        press_enter();
        tick(4);
        n_cmp++;
        if (n_start - s0 !== 0 || n_to - t0 !== 1) begin
            n_err++; $display("FAIL to_counts: start %0d to %0d want 0 1", n_start - s0, n_to - t0);
        end
    endtask

    task automatic test_reset_mid();
        int s0, d0;
        press_op(3'b010, 1'b1);
        press_enter();
        tick(2);
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({alu_start, alu_sub, disp_load, err_illegal, err_timeout, busy} !== 6'b0) begin
            n_err++;
            $display("FAIL reset_mid: got %b want 000000",
                     {alu_start, alu_sub, disp_load, err_illegal, err_timeout, busy});
        end
        tick(2);
        rst = 1'b0;
        s0 = n_start; d0 = n_disp;
        tick(4);
        n_cmp++;
        if (busy !== 1'b0 || n_start - s0 !== 0 || n_disp - d0 !== 0) begin
            n_err++; $display("FAIL reset_release: busy %b start %0d disp %0d want 0 0 0",
                              busy, n_start - s0, n_disp - d0);
        end
    endtask

    task automatic test_queue();
        int s0;
        logic sub_seen;
        s0 = n_start; sub_seen = 1'b0;
        press_op(3'b001, 1'b0);
        press_enter();
        tick(2);
        press_op(3'b010, 1'b0);
        tick();
        alu_done = 1'b1;
        tick();
        alu_done = 1'b0;
`ifdef OPCODE_DECODER_QUEUE_EN
        n_cmp++;
        if (busy !== 1'b1) begin n_err++; $display("FAIL queue_wait_enter: busy got %b want 1", busy); end
        press_enter();
        tick();
        sub_seen = alu_sub;
        n_cmp++;
        if (alu_start !== 1'b1 || sub_seen !== 1'b1) begin
            n_err++; $display("FAIL queue_issue: start/sub got %b%b want 11", alu_start, sub_seen);
        end
        tick(2);
        alu_done = 1'b1;
        tick();
        alu_done = 1'b0;
        n_cmp++;
        if (busy !== 1'b0 || n_start - s0 !== 2) begin
            n_err++; $display("FAIL queue_end: busy %b start %0d want 0 2", busy, n_start - s0);
        end
`else
        n_cmp++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL drop_idle: busy got %b want 0", busy); end
        press_enter();
        tick(4);
        n_cmp++;
        if (busy !== 1'b0 || n_start - s0 !== 1) begin
            n_err++; $display("FAIL drop_end: busy %b start %0d want 0 1", busy, n_start - s0);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_basic_add();
        test_last_wins();
        test_illegal();
        test_timeout();
        test_reset_mid();
        test_queue();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
